// File: rtl/dual_port_ram.sv
// Simple dual-port synchronous RAM with one write port, one registered read port and a synchronous active-low clear.
// Define DUAL_PORT_RAM_BYPASS_EN for write-first forwarding on same-address collisions (default: read-before-write).
module dual_port_ram #(
  parameter int ADDRESS_DEPTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_SIZE  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    we,
  input  logic [ADDRESS_SIZE-1:0] wr_addr,
  input  logic                    re,
  input  logic [ADDRESS_SIZE-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [ADDRESS_DEPTH];
  logic                  wr_in_range;
  logic                  rd_in_range;

  // Addresses at or beyond the stored depth are not backed by storage.
  assign wr_in_range = (int'(wr_addr) < ADDRESS_DEPTH);
  assign rd_in_range = (int'(rd_addr) < ADDRESS_DEPTH);

`ifdef DUAL_PORT_RAM_BYPASS_EN
  logic collide;
  assign collide = we && wr_in_range && (wr_addr == rd_addr);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ADDRESS_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (we && wr_in_range) begin
        mem[wr_addr] <= wr_data;
      end
      // Without bypass the read sees the pre-edge word, giving read-before-write on collisions.
      if (re) begin
        if (!rd_in_range) begin
          rd_data <= '0;
`ifdef DUAL_PORT_RAM_BYPASS_EN
        end else if (collide) begin
          rd_data <= wr_data;
`endif
        end else begin
          rd_data <= mem[rd_addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard testbench for dual_port_ram: stimulus queues expected read data, a monitor checks it after each edge.
module tb_dual_port_ram;

  logic       clk;
  logic       rst;
  logic [7:0] wr_data;
  logic       we;
  logic [3:0] wr_addr;
  logic       re;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  logic       chk;
  logic [7:0] expq [$];
  string      nameq [$];
  int         vectors;
  int         errors;

  dual_port_ram #(
    .ADDRESS_DEPTH(16),
    .DATA_WIDTH(8),
    .ADDRESS_SIZE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_data(wr_data),
    .we(we),
    .wr_addr(wr_addr),
    .re(re),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput();
    logic [7:0] exp;
    string      nm;
    vectors++;
    if (expq.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_underflow: got rd_data=%02h, required a queued expectation", rd_data);
    end else begin
      exp = expq.pop_front();
      nm  = nameq.pop_front();
      if (rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL %s: got rd_data=%02h, required %02h", nm, rd_data, exp);
      end
    end
  endtask

  // Monitor: an edge whose stimulus carried a check presents its result just after that edge.
  always @(posedge clk) begin
    automatic logic c = chk;
    #1;
    if (c) checkOutput();
  end

  task automatic applyStimulus(input logic r, input logic w, input logic [3:0] wa,
                               input logic [7:0] wd, input logic rr, input logic [3:0] ra,
                               input logic c, input logic [7:0] exp, input string nm);
    @(negedge clk);
    rst = r; we = w; wr_addr = wa; wr_data = wd; re = rr; rd_addr = ra; chk = c;
    if (c) begin
      expq.push_back(exp);
      nameq.push_back(nm);
    end
  endtask

  localparam logic [7:0] COLLIDE_EXP =
`ifdef DUAL_PORT_RAM_BYPASS_EN
    8'h22;
`else
    8'h11;
`endif

  initial begin
    vectors = 0; errors = 0;
    rst = 1'b0; we = 1'b0; re = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0; chk = 1'b0;

    applyStimulus(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, "reset_initial");
    applyStimulus(1, 1, 4, 8'h5A, 0, 0, 0, 8'h00, "");
    applyStimulus(1, 1, 7, 8'h3C, 0, 0, 0, 8'h00, "");
    applyStimulus(1, 0, 0, 8'h00, 1, 4, 1, 8'h5A, "pre_reset_read");
    applyStimulus(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, "reset_clears_rd_data");
    for (int i = 0; i < 16; i++)
      applyStimulus(1, 0, 0, 8'h00, 1, 4'(i), 1, 8'h00, $sformatf("reset_mem_%0d", i));

    applyStimulus(1, 1, 6, 8'h0F, 0, 0, 0, 8'h00, "");
    applyStimulus(1, 0, 6, 8'h0F, 0, 0, 0, 8'h00, "");
    applyStimulus(1, 0, 6, 8'hEE, 1, 6, 1, 8'h0F, "basic_read_6");
    applyStimulus(1, 0, 0, 8'h00, 0, 3, 1, 8'h0F, "hold_re0_a");
    applyStimulus(1, 0, 6, 8'h77, 0, 3, 1, 8'h0F, "hold_re0_b");
    applyStimulus(1, 0, 0, 8'h00, 1, 6, 1, 8'h0F, "we0_no_change_6");

    for (int i = 0; i < 16; i++)
      applyStimulus(1, 1, 4'(i), 8'hA0 + 8'(i), 0, 0, 0, 8'h00, "");
    applyStimulus(1, 0, 5, 8'hFF, 0, 0, 0, 8'h00, "");
    for (int i = 15; i >= 0; i--)
      applyStimulus(1, 0, 0, 8'h00, 1, 4'(i), 1, 8'hA0 + 8'(i), $sformatf("sweep_%0d", i));

    // Independent ports: write addr 3 while reading addr 12 in the same cycle.
    applyStimulus(1, 1, 3, 8'h33, 1, 12, 1, 8'hAC, "indep_read_12");
    applyStimulus(1, 0, 0, 8'h00, 1, 3, 1, 8'h33, "indep_written_3");

    applyStimulus(1, 1, 9, 8'h11, 0, 0, 0, 8'h00, "");
    applyStimulus(1, 1, 9, 8'h22, 1, 9, 1, COLLIDE_EXP, "collision_9");
    applyStimulus(1, 0, 0, 8'h00, 1, 9, 1, 8'h22, "post_collision_9");

    applyStimulus(0, 1, 2, 8'h55, 1, 2, 1, 8'h00, "reset_priority");
    applyStimulus(1, 0, 0, 8'h00, 1, 2, 1, 8'h00, "reset_priority_addr2");
    applyStimulus(1, 0, 0, 8'h00, 1, 9, 1, 8'h00, "reset_cleared_9");

    applyStimulus(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, "");
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
